// File: rtl/secure_rf_pkg.sv
// Shared types for the owner-tagged secure register file.
package secure_rf_pkg;

  typedef enum logic [1:0] {
    SCRUB = 2'd0,
    IDLE  = 2'd1,
    LOCK  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GRANT   = 2'd0,
    UNOWNED = 2'd1,
    DENY    = 2'd2
  } acc_e;

endpackage

// File: rtl/rf_access_check.sv
// Classifies one access from an entry's valid bit, its owner and the requesting UID.
module rf_access_check
  import secure_rf_pkg::*;
#(
  parameter int unsigned UID_W = 12
) (
  input  logic             valid,
  input  logic [UID_W-1:0] owner,
  input  logic [UID_W-1:0] req_uid,
  output acc_e             result_c
);

  always_comb begin
    result_c = UNOWNED;
    if (valid) begin
      result_c = (owner == req_uid) ? GRANT : DENY;
    end
  end

endmodule

// File: rtl/secure_reg_file.sv
// Owner-tagged register file with violation counting, timed lockout and
// post-reset scrubbing of all entries.
module secure_reg_file
  import secure_rf_pkg::*;
#(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned UID_W       = 12,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = $clog2(DEPTH),
  parameter int unsigned MAX_VIOL    = 3,
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [UID_W-1:0]              REQ_UID,
  input  logic                          WR_EN,
  input  logic                          REL_EN,
  input  logic [ADDR_W-1:0]             WR_ADDR,
  input  logic [DATA_W-1:0]             WR_DATA,
  input  logic                          RD_EN,
  input  logic [ADDR_W-1:0]             RD_ADDR1,
  input  logic [ADDR_W-1:0]             RD_ADDR2,
  output logic [DATA_W-1:0]             RD_DATA1,
  output logic [DATA_W-1:0]             RD_DATA2,
  output logic                          RD_VALID,
  output logic                          RD_DENY1,
  output logic                          RD_DENY2,
  output logic                          WR_DENY,
  output logic [UID_W-1:0]              OWNER_OUT,
  output logic                          BUSY,
  output logic                          LOCKED,
  output logic [$clog2(MAX_VIOL+1)-1:0] VIOL_CNT
);

  localparam int unsigned VIOL_W = $clog2(MAX_VIOL + 1);
  localparam int unsigned TMR_W  = $clog2(LOCK_CYCLES + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   scrub_idx_q, scrub_idx_d;
  logic [TMR_W-1:0]    lock_tmr_q, lock_tmr_d;
  logic [VIOL_W-1:0]   viol_cnt_q, viol_cnt_d;
  logic [DATA_W-1:0]   data_q  [DEPTH];
  logic [DATA_W-1:0]   data_d  [DEPTH];
  logic [UID_W-1:0]    owner_q [DEPTH];
  logic [UID_W-1:0]    owner_d [DEPTH];
  logic [DEPTH-1:0]    valid_q, valid_d;

  logic [DATA_W-1:0]   rd_data1_q, rd_data1_d, rd_data2_q, rd_data2_d;
  logic [UID_W-1:0]    owner_out_q, owner_out_d;
  logic                rd_valid_q, rd_valid_d, rd_deny1_q, rd_deny1_d, rd_deny2_q, rd_deny2_d;
  logic                wr_deny_q, wr_deny_d, busy_q, busy_d, locked_q, locked_d;

  acc_e                wr_res_c, rd1_res_c, rd2_res_c;
  logic                viol_c;

  rf_access_check #(.UID_W(UID_W)) u_chk_wr (
    .valid(valid_q[WR_ADDR]), .owner(owner_q[WR_ADDR]), .req_uid(REQ_UID), .result_c(wr_res_c)
  );
  rf_access_check #(.UID_W(UID_W)) u_chk_rd1 (
    .valid(valid_q[RD_ADDR1]), .owner(owner_q[RD_ADDR1]), .req_uid(REQ_UID), .result_c(rd1_res_c)
  );
  rf_access_check #(.UID_W(UID_W)) u_chk_rd2 (
    .valid(valid_q[RD_ADDR2]), .owner(owner_q[RD_ADDR2]), .req_uid(REQ_UID), .result_c(rd2_res_c)
  );

  always_comb begin
    state_d     = state_q;
    scrub_idx_d = scrub_idx_q;
    lock_tmr_d  = lock_tmr_q;
    viol_cnt_d  = viol_cnt_q;
    data_d      = data_q;
    owner_d     = owner_q;
    valid_d     = valid_q;
    rd_data1_d  = '0;
    rd_data2_d  = '0;
    owner_out_d = '0;
    rd_valid_d  = 1'b0;
    rd_deny1_d  = 1'b0;
    rd_deny2_d  = 1'b0;
    wr_deny_d   = 1'b0;
    viol_c      = 1'b0;

    case (state_q)
      SCRUB: begin
        data_d[scrub_idx_q]  = '0;
        owner_d[scrub_idx_q] = '0;
        if (scrub_idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d     = IDLE;
          scrub_idx_d = '0;
        end else begin
          scrub_idx_d = scrub_idx_q + ADDR_W'(1);
        end
      end

      IDLE: begin
        if (WR_EN) begin
          if (wr_res_c == DENY) begin
            wr_deny_d = 1'b1;
            viol_c    = 1'b1;
          end else begin
            data_d[WR_ADDR]  = WR_DATA;
            owner_d[WR_ADDR] = REQ_UID;
            valid_d[WR_ADDR] = 1'b1;
          end
        end else if (REL_EN) begin
          if (wr_res_c == DENY) begin
            wr_deny_d = 1'b1;
            viol_c    = 1'b1;
          end else if (wr_res_c == GRANT) begin
            data_d[WR_ADDR]  = '0;
            owner_d[WR_ADDR] = '0;
            valid_d[WR_ADDR] = 1'b0;
          end
        end

        // Reads see pre-write contents: they sample the _q arrays.
        if (RD_EN) begin
          rd_valid_d  = 1'b1;
          owner_out_d = valid_q[RD_ADDR1] ? owner_q[RD_ADDR1] : '0;
          if (rd1_res_c == GRANT) rd_data1_d = data_q[RD_ADDR1];
          if (rd2_res_c == GRANT) rd_data2_d = data_q[RD_ADDR2];
          if (rd1_res_c == DENY) begin
            rd_deny1_d = 1'b1;
            viol_c     = 1'b1;
          end
          if (rd2_res_c == DENY) begin
            rd_deny2_d = 1'b1;
            viol_c     = 1'b1;
          end
        end

        if (viol_c) begin
          viol_cnt_d = viol_cnt_q + VIOL_W'(1);
          if (viol_cnt_q == VIOL_W'(MAX_VIOL - 1)) begin
            state_d    = LOCK;
            lock_tmr_d = TMR_W'(LOCK_CYCLES - 1);
          end
        end
      end

      LOCK: begin
        wr_deny_d = WR_EN | REL_EN;
        if (RD_EN) begin
          rd_valid_d = 1'b1;
          rd_deny1_d = 1'b1;
          rd_deny2_d = 1'b1;
        end
        if (lock_tmr_q == '0) begin
          state_d    = IDLE;
          viol_cnt_d = '0;
        end else begin
          lock_tmr_d = lock_tmr_q - TMR_W'(1);
        end
      end

      default: state_d = SCRUB;
    endcase

    busy_d   = (state_d == SCRUB);
    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= SCRUB;
      scrub_idx_q <= '0;
      lock_tmr_q  <= '0;
      viol_cnt_q  <= '0;
      valid_q     <= '0;
      rd_data1_q  <= '0;
      rd_data2_q  <= '0;
      owner_out_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_deny1_q  <= 1'b0;
      rd_deny2_q  <= 1'b0;
      wr_deny_q   <= 1'b0;
      busy_q      <= 1'b1;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      scrub_idx_q <= scrub_idx_d;
      lock_tmr_q  <= lock_tmr_d;
      viol_cnt_q  <= viol_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      owner_q     <= owner_d;
      rd_data1_q  <= rd_data1_d;
      rd_data2_q  <= rd_data2_d;
      owner_out_q <= owner_out_d;
      rd_valid_q  <= rd_valid_d;
      rd_deny1_q  <= rd_deny1_d;
      rd_deny2_q  <= rd_deny2_d;
      wr_deny_q   <= wr_deny_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
    end
  end

  assign RD_DATA1  = rd_data1_q;
  assign RD_DATA2  = rd_data2_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_DENY1  = rd_deny1_q;
  assign RD_DENY2  = rd_deny2_q;
  assign WR_DENY   = wr_deny_q;
  assign OWNER_OUT = owner_out_q;
  assign BUSY      = busy_q;
  assign LOCKED    = locked_q;
  assign VIOL_CNT  = viol_cnt_q;

endmodule

// File: doc/secure_reg_file.md
Name: secure_reg_file

Overview:
Parametrised successor to the owner-tagged register file. Every entry carries a data word, an owner UID and a valid (owned) bit. Reads and writes are checked against the requesting UID, and violations are counted. Repeated violations put the block into a timed lockout, and entries are zeroised after reset and on release. It sits between the switch/button front end and the display mux, feeding RS1/RS2/owner to the seven-segment path.

Parameters:
DATA_W, 12, data word width
UID_W, 12, user-ID width
DEPTH, 16, number of entries (power of two)
ADDR_W, $clog2(DEPTH), address width
MAX_VIOL, 3, violations that trigger lockout (>=1)
LOCK_CYCLES, 1024, lockout duration in clocks (>=1)

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
REQ_UID  in  UID_W  UID of the current requester (applies to all accesses this cycle)
WR_EN  in  1  write request
REL_EN  in  1  release request for entry WR_ADDR (WR_EN has priority)
WR_ADDR  in  ADDR_W  write/release address
WR_DATA  in  DATA_W  write data
RD_EN  in  1  read request, both ports
RD_ADDR1  in  ADDR_W  read port 1 address
RD_ADDR2  in  ADDR_W  read port 2 address
RD_DATA1  out  DATA_W  registered read data, port 1
RD_DATA2  out  DATA_W  registered read data, port 2
RD_VALID  out  1  read data valid, pulses 1 cycle after an accepted RD_EN
RD_DENY1  out  1  port 1 read denied
RD_DENY2  out  1  port 2 read denied
WR_DENY  out  1  write/release denied, 1 cycle after request
OWNER_OUT  out  UID_W  owner of RD_ADDR1 (0 if unowned), registered with RD_DATA1
BUSY  out  1  scrub in progress
LOCKED  out  1  lockout active
VIOL_CNT  out  $clog2(MAX_VIOL+1)  current violation count

Behaviour:
- Single clock CLK; reset is synchronous and active-high on RST.
- FSM states: SCRUB, IDLE, LOCK.
- RST=1: state<=SCRUB, scrub index<=0, all valid bits<=0, VIOL_CNT<=0, and all outputs 0 except BUSY=1.
- SCRUB: zeroises data and owner at index i, one entry per cycle. After i=DEPTH-1 it goes to IDLE, so BUSY is high for exactly DEPTH cycles after RST falls. All requests are ignored with no deny and no RD_VALID.
- IDLE write (WR_EN):
  - Entry unowned: store WR_DATA, owner<=REQ_UID, valid<=1 (claim).
  - Owner==REQ_UID: store WR_DATA.
  - Otherwise: storage unchanged, WR_DENY=1 next cycle, violation.
- IDLE release (REL_EN, no WR_EN):
  - Owner match: data<=0, owner<=0, valid<=0.
  - Unowned: no-op, no deny.
  - Mismatch: denied, violation.
- IDLE read (RD_EN), per port, result registered (1-cycle latency):
  - Owned and match: RD_DATAn=data.
  - Unowned: RD_DATAn=0, no deny.
  - Mismatch: RD_DATAn=0, RD_DENYn=1, violation.
  - OWNER_OUT reflects RD_ADDR1 regardless of match.
- Same-cycle read and write to the same address: read returns the pre-write value.
- Deny/data outputs are 0 in any cycle without a corresponding request.
- Violation counting: VIOL_CNT increments by exactly 1 per cycle containing one or more violations. When the increment reaches MAX_VIOL: state<=LOCK, lock timer<=LOCK_CYCLES-1.
- LOCK:
  - LOCKED=1; storage is frozen.
  - Every WR_EN/REL_EN gets WR_DENY. Every RD_EN gets RD_DENY1=RD_DENY2=1 with zero data and RD_VALID=1.
  - No further counting.
  - Timer reaching 0 moves to IDLE, VIOL_CNT<=0, LOCKED falls.
  - Lockout lasts exactly LOCK_CYCLES cycles. Contents survive lockout.
- RST at any time, including mid-scrub or mid-lock, restarts SCRUB.
- Unsigned arithmetic; the scrub index and lock timer wrap only via explicit reload.

Decomposition:
- Package secure_rf_pkg: state enum (SCRUB/IDLE/LOCK) and an access-result enum (GRANT/UNOWNED/DENY).
- One sub-module, rf_access_check: combinational owner/valid/REQ_UID comparison returning the access result. It is instantiated three times (write/release, read 1, read 2).
- Storage arrays, FSM and counters stay in the top.

Test Plan:
- Reset then idle → BUSY=1 for 16 cycles; afterwards reading all addresses as UID 0x0A1 gives RD_DATA=0, no deny.
- UID 0x0A1 writes 0x5A5 to addr 3, then reads addr 3 → RD_DATA1=0x5A5, OWNER_OUT=0x0A1, 1-cycle latency.
- UID 0x0B2 writes addr 3 → WR_DENY=1, VIOL_CNT=1, addr 3 still reads 0x5A5 for 0x0A1.
- Same cycle: UID 0x0B2 reads addr 3 on both ports with a denied write → VIOL_CNT increments by 1 only. Third violation → LOCKED=1 for LOCK_CYCLES (set 8 in bench). All accesses denied during lockout; afterwards VIOL_CNT=0 and data is intact.
- 0x0A1 releases addr 3 → valid cleared; 0x0B2 then claims it with 0x123 and reads back 0x123.
- Same-cycle write 0x777 and read of addr 5 (owner) → read returns old value. RST asserted mid-lock → SCRUB restarts and addr 5 reads 0 afterwards.
